// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the gate-block exerciser.
//   state_t     : checker FSM states.
//   GATE_*      : bit positions of each gate in the error mask / golden vector.
//   golden()    : expected eight gate outputs for one (a, b) input pair.
//   popcount8() : number of set bits in an 8-bit mismatch vector.
package gate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int GATE_NOTA = 0;
  localparam int GATE_NOTB = 1;
  localparam int GATE_OR   = 2;
  localparam int GATE_NOR  = 3;
  localparam int GATE_AND  = 4;
  localparam int GATE_NAND = 5;
  localparam int GATE_XOR  = 6;
  localparam int GATE_XNOR = 7;

  function automatic logic [7:0] golden(input logic a, input logic b);
    logic [7:0] g;
    g            = 8'h00;
    g[GATE_NOTA] = ~a;
    g[GATE_NOTB] = ~b;
    g[GATE_OR]   = a | b;
    g[GATE_NOR]  = ~(a | b);
    g[GATE_AND]  = a & b;
    g[GATE_NAND] = ~(a & b);
    g[GATE_XOR]  = a ^ b;
    g[GATE_XNOR] = ~(a ^ b);
    return g;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gate_ref.sv
// gate_ref: combinational golden model of the two-input, eight-output gate block.
//   a, b     : input vector currently being driven.
//   expected : golden outputs in error-mask order (see gate_pkg GATE_*).
module gate_ref
  import gate_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [7:0] expected
);

  assign expected = golden(a, b);

endmodule

// File: rtl/gate_checker.sv
// gate_checker: BIST engine that sweeps a/b through 00,01,10,11, lets the gate
// block settle, samples its eight outputs and accumulates mismatches.
//   clk, rst          : clock (rising edge) and asynchronous active-high reset.
//   start             : run request, honoured only in IDLE or DONE.
//   a_out, b_out      : registered stimulus to the gate block.
//   nota_in..xnor_in  : observed gate outputs.
//   busy, done, pass  : run status; pass is meaningful while done is high.
//   err_mask          : sticky per-gate mismatch flags.
//   err_count         : saturating count of mismatched output bits.
module gate_checker
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned NUM_PASSES    = 1,
  parameter int unsigned ERRW          = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            a_out,
  output logic            b_out,
  input  logic            nota_in,
  input  logic            notb_in,
  input  logic            or_in,
  input  logic            nor_in,
  input  logic            and_in,
  input  logic            nand_in,
  input  logic            xor_in,
  input  logic            xnor_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      err_mask,
  output logic [ERRW-1:0] err_count
);

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]      PASS_LAST   = 8'(NUM_PASSES - 1);
  localparam logic [ERRW-1:0] CNT_MAX     = {ERRW{1'b1}};

  state_t            state_r, state_nxt_s;
  logic [1:0]        vec_r, vec_nxt_s;
  logic [7:0]        pass_cnt_r, pass_cnt_nxt_s;
  logic [3:0]        settle_cnt_r, settle_cnt_nxt_s;
  logic [7:0]        err_mask_r, err_mask_nxt_s;
  logic [ERRW-1:0]   err_count_r, err_count_nxt_s;
  logic              busy_r, done_r, pass_r;
  logic              busy_nxt_s, done_nxt_s, pass_nxt_s;
  logic [7:0]        golden_s, observed_s, mismatch_s;
  logic [ERRW+3:0]   sum_s;

  gate_ref u_ref (
    .a        (vec_r[1]),
    .b        (vec_r[0]),
    .expected (golden_s)
  );

  assign observed_s = {xnor_in, xor_in, nand_in, and_in, nor_in, or_in, notb_in, nota_in};
  assign mismatch_s = observed_s ^ golden_s;
  // Widened so that adding up to 8 never wraps before the saturation compare.
  assign sum_s      = {4'b0000, err_count_r} + {{ERRW{1'b0}}, popcount8(mismatch_s)};

  // Next-state, counter, accumulator and status-flag logic.
  always_comb begin
    state_nxt_s      = state_r;
    vec_nxt_s        = vec_r;
    pass_cnt_nxt_s   = pass_cnt_r;
    settle_cnt_nxt_s = settle_cnt_r;
    err_mask_nxt_s   = err_mask_r;
    err_count_nxt_s  = err_count_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          err_mask_nxt_s   = 8'h00;
          err_count_nxt_s  = {ERRW{1'b0}};
          pass_cnt_nxt_s   = 8'd0;
          settle_cnt_nxt_s = 4'd0;
          vec_nxt_s        = 2'd0;
          state_nxt_s      = SETTLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) begin
          settle_cnt_nxt_s = 4'd0;
          state_nxt_s      = SAMPLE;
        end else begin
          settle_cnt_nxt_s = settle_cnt_r + 4'd1;
        end
      end
      SAMPLE: begin
        err_mask_nxt_s = err_mask_r | mismatch_s;
        if (sum_s > {4'b0000, CNT_MAX}) begin
          err_count_nxt_s = CNT_MAX;
        end else begin
          err_count_nxt_s = sum_s[ERRW-1:0];
        end
        if (vec_r != 2'd3) begin
          vec_nxt_s   = vec_r + 2'd1;
          state_nxt_s = SETTLE;
        end else if (pass_cnt_r < PASS_LAST) begin
          pass_cnt_nxt_s = pass_cnt_r + 8'd1;
          vec_nxt_s      = 2'd0;
          state_nxt_s    = SETTLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s == SETTLE) || (state_nxt_s == SAMPLE);
    done_nxt_s = (state_nxt_s == DONE);
    pass_nxt_s = done_nxt_s && (err_mask_nxt_s == 8'h00);
  end

  // State, counters, accumulators and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      vec_r        <= 2'd0;
      pass_cnt_r   <= 8'd0;
      settle_cnt_r <= 4'd0;
      err_mask_r   <= 8'h00;
      err_count_r  <= {ERRW{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      vec_r        <= vec_nxt_s;
      pass_cnt_r   <= pass_cnt_nxt_s;
      settle_cnt_r <= settle_cnt_nxt_s;
      err_mask_r   <= err_mask_nxt_s;
      err_count_r  <= err_count_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      pass_r       <= pass_nxt_s;
    end
  end

  assign a_out     = vec_r[1];
  assign b_out     = vec_r[0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_mask  = err_mask_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: drives two checker instances (default parameters, and
// SETTLE_CYCLES=3 / NUM_PASSES=3 / ERRW=3) against a behavioural gate block
// with configurable stuck-at/invert faults and 0..2 cycles of output delay.
module tb_gate_checker;

  localparam int A_S = 1, A_P = 1, A_E = 8;
  localparam int B_S = 3, B_P = 3, B_E = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;
  logic a_out_a, b_out_a, busy_a, done_a, pass_a;
  logic a_out_b, b_out_b, busy_b, done_b, pass_b;
  logic [7:0] mask_a, mask_b;
  logic [A_E-1:0] cnt_a;
  logic [B_E-1:0] cnt_b;
  logic [7:0] obs_a, obs_b;

  // Gate block fault configuration per instance.
  logic [7:0] s0_a, s1_a, inv_a, s0_b, s1_b, inv_b;
  int dly_a, dly_b;
  logic a1_a, b1_a, a2_a, b2_a, a1_b, b1_b, a2_b, b2_b;
  logic ga, gb, gc, gd;

  int checks = 0;
  int errors = 0;

  // Ideal gate behaviour from plain arithmetic on the input values.
  function automatic logic [7:0] ideal(input logic a, input logic b);
    int ai, bi;
    logic [7:0] r;
    ai = int'(a);
    bi = int'(b);
    r[0] = (ai == 0);
    r[1] = (bi == 0);
    r[2] = (ai + bi > 0);
    r[3] = (ai + bi == 0);
    r[4] = (ai * bi == 1);
    r[5] = (ai * bi == 0);
    r[6] = ((ai + bi) % 2 == 1);
    r[7] = ((ai + bi) % 2 == 0);
    return r;
  endfunction

  always @(posedge clk) begin
    a1_a <= a_out_a; b1_a <= b_out_a; a2_a <= a1_a; b2_a <= b1_a;
    a1_b <= a_out_b; b1_b <= b_out_b; a2_b <= a1_b; b2_b <= b1_b;
  end

  always_comb begin
    ga = a_out_a; gb = b_out_a;
    if (dly_a == 1) begin ga = a1_a; gb = b1_a; end
    else if (dly_a == 2) begin ga = a2_a; gb = b2_a; end
    obs_a = ((ideal(ga, gb) & ~s0_a) | s1_a) ^ inv_a;
    gc = a_out_b; gd = b_out_b;
    if (dly_b == 1) begin gc = a1_b; gd = b1_b; end
    else if (dly_b == 2) begin gc = a2_b; gd = b2_b; end
    obs_b = ((ideal(gc, gd) & ~s0_b) | s1_b) ^ inv_b;
  end

  gate_checker #(.SETTLE_CYCLES(A_S), .NUM_PASSES(A_P), .ERRW(A_E)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .a_out(a_out_a), .b_out(b_out_a),
    .nota_in(obs_a[0]), .notb_in(obs_a[1]), .or_in(obs_a[2]), .nor_in(obs_a[3]),
    .and_in(obs_a[4]), .nand_in(obs_a[5]), .xor_in(obs_a[6]), .xnor_in(obs_a[7]),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_mask(mask_a), .err_count(cnt_a)
  );

  gate_checker #(.SETTLE_CYCLES(B_S), .NUM_PASSES(B_P), .ERRW(B_E)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .a_out(a_out_b), .b_out(b_out_b),
    .nota_in(obs_b[0]), .notb_in(obs_b[1]), .or_in(obs_b[2]), .nor_in(obs_b[3]),
    .and_in(obs_b[4]), .nand_in(obs_b[5]), .xor_in(obs_b[6]), .xnor_in(obs_b[7]),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_mask(mask_b), .err_count(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get(input int which, output logic bz, output logic dn, output logic ps,
                     output logic [7:0] m, output logic [7:0] c, output logic [1:0] ab);
    if (which == 0) begin
      bz = busy_a; dn = done_a; ps = pass_a; m = mask_a; c = 8'(cnt_a); ab = {a_out_a, b_out_a};
    end else begin
      bz = busy_b; dn = done_b; ps = pass_b; m = mask_b; c = 8'(cnt_b); ab = {a_out_b, b_out_b};
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_a = v; else start_b = v;
  endtask

  // Reference: walk every pass and vector, count mismatched bits, saturate.
  task automatic model(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] inv,
                       input int P, input int E, output logic [7:0] m, output int c);
    logic [7:0] id, mm;
    m = 8'h00;
    c = 0;
    for (int p = 0; p < P; p++) begin
      for (int v = 0; v < 4; v++) begin
        id = ideal(logic'(v / 2), logic'(v % 2));
        mm = (((id & ~s0) | s1) ^ inv) ^ id;
        m  = m | mm;
        c  = c + $countones(mm);
      end
    end
    if (c > (1 << E) - 1) c = (1 << E) - 1;
  endtask

  task automatic run(input int which, input string tag, input logic [7:0] s0,
                     input logic [7:0] s1, input logic [7:0] inv, input int dly,
                     input int pulse_at, input bit track);
    int S, P, E, lat, cyc, ec;
    logic bz, dn, ps;
    logic [7:0] m, c, em;
    logic [1:0] ab;
    S = (which == 0) ? A_S : B_S;
    P = (which == 0) ? A_P : B_P;
    E = (which == 0) ? A_E : B_E;
    if (which == 0) begin s0_a = s0; s1_a = s1; inv_a = inv; dly_a = dly; end
    else begin s0_b = s0; s1_b = s1; inv_b = inv; dly_b = dly; end
    @(negedge clk);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    lat = 4 * (S + 1) * P;
    cyc = 0;
    get(which, bz, dn, ps, m, c, ab);
    while (!dn && cyc < lat + 20) begin
      check($sformatf("%s_busy_c%0d", tag, cyc), 32'(bz), 32'd1);
      if (track) check($sformatf("%s_vec_c%0d", tag, cyc), 32'(ab), 32'((cyc / (S + 1)) % 4));
      set_start(which, (cyc == pulse_at) ? 1'b1 : 1'b0);
      @(negedge clk);
      cyc++;
      get(which, bz, dn, ps, m, c, ab);
    end
    set_start(which, 1'b0);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_busy_end"}, 32'(bz), 32'd0);
    if (dly <= S) begin
      model(s0, s1, inv, P, E, em, ec);
      check({tag, "_mask"}, 32'(m), 32'(em));
      check({tag, "_count"}, 32'(c), 32'(ec));
      check({tag, "_pass"}, 32'(ps), 32'(em == 8'h00));
    end else begin
      check({tag, "_pass"}, 32'(ps), 32'd0);
      check({tag, "_mask_nz"}, 32'(m != 8'h00), 32'd1);
    end
    @(negedge clk);
    get(which, bz, dn, ps, m, c, ab);
    check({tag, "_done_hold"}, 32'(dn), 32'd1);
  endtask

  task automatic check_idle(input int which, input string tag);
    logic bz, dn, ps;
    logic [7:0] m, c;
    logic [1:0] ab;
    get(which, bz, dn, ps, m, c, ab);
    check({tag, "_busy"}, 32'(bz), 32'd0);
    check({tag, "_done"}, 32'(dn), 32'd0);
    check({tag, "_pass"}, 32'(ps), 32'd0);
    check({tag, "_mask"}, 32'(m), 32'd0);
    check({tag, "_count"}, 32'(c), 32'd0);
    check({tag, "_ab"}, 32'(ab), 32'd0);
  endtask

  initial begin
    logic [7:0] r0, r1, ri;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    s0_a = 8'h00; s1_a = 8'h00; inv_a = 8'h00; dly_a = 0;
    s0_b = 8'h00; s1_b = 8'h00; inv_b = 8'h00; dly_b = 0;
    repeat (3) @(negedge clk);
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    rst = 1'b0;
    @(negedge clk);
    check_idle(0, "idle_a");

    run(0, "clean_a", 8'h00, 8'h00, 8'h00, 0, -1, 1'b1);
    run(0, "xor_s0", 8'h40, 8'h00, 8'h00, 0, -1, 1'b0);
    run(0, "pulse_mid", 8'h00, 8'h00, 8'h00, 0, 2, 1'b0);
    run(0, "dly2_s1", 8'h00, 8'h00, 8'h00, 2, -1, 1'b0);
    run(0, "dly1_s1", 8'h00, 8'h00, 8'h00, 1, -1, 1'b0);

    run(1, "xnor_s1", 8'h00, 8'h80, 8'h00, 0, -1, 1'b1);
    run(1, "sat_inv", 8'h00, 8'h00, 8'hFF, 0, -1, 1'b0);
    run(1, "dly2_s3", 8'h00, 8'h00, 8'h00, 2, -1, 1'b0);

    // Asynchronous reset in the middle of a failing run.
    s0_a = 8'h00; s1_a = 8'h00; inv_a = 8'hFF; dly_a = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle(0, "midrst_a");
    @(negedge clk);
    rst = 1'b0;
    run(0, "after_rst", 8'h00, 8'h00, 8'h00, 0, -1, 1'b1);
    run(1, "after_rst_b", 8'h00, 8'h00, 8'h00, 0, -1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      r0 = 8'($urandom); r1 = 8'($urandom) & ~r0; ri = 8'($urandom);
      if (i % 3 == 0) begin r0 = 8'h00; r1 = 8'h00; end
      run(0, $sformatf("rnd_a%0d", i), r0, r1, ri & 8'($urandom), int'($urandom_range(1, 0)), -1, 1'b0);
      r0 = 8'($urandom); r1 = 8'($urandom) & ~r0; ri = 8'($urandom);
      if (i % 2 == 0) ri = 8'h00;
      run(1, $sformatf("rnd_b%0d", i), r0, r1, ri, int'($urandom_range(2, 0)), int'($urandom_range(10, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
